fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core, directly upstream of the main control decoder. Holds the PC and issues word reads to instruction memory over a req/ready handshake. Presents the fetched instruction, with opcode and funct fields split out for the decoder, under a valid/ack handshake. Selects the next PC from the jump, branch and JR controls sampled when the instruction is retired.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ready handshake, instruction hold with valid/ack.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirects into ERR instead of masking the low bits.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [5:0]        instr_op_o,
  output logic [5:0]        instr_funct_o,
  output logic              instr_valid_o,
  input  logic              instr_ack_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  input  logic              jump_ctl_i,
  input  logic              branch_ctl_i,
  input  logic              branch_taken_i,
  input  logic              jr_ctl_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic              fetch_err_o
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1, S_ERR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_HOLD = 2'd1} state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_instr;
  logic                r_valid;
  logic                w_capture;
  logic                w_retire;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [ADDR_W-1:0]   w_br_off;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_pc_nxt;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // Redirect priority: JR, then J/JAL, then taken branch, else sequential.
  always_comb begin
    w_target = w_pc_plus4;
    if (jr_ctl_i) begin
      w_target = jr_target_i;
    end else if (jump_ctl_i) begin
      w_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (branch_ctl_i && branch_taken_i) begin
      w_target = w_pc_plus4 + w_br_off;
    end else begin
      w_target = w_pc_plus4;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_pc_nxt = w_target;
`else
  assign w_pc_nxt = w_target & ~32'd3;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; ready counts only while the request is actually driven.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_req && imem_ready_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_HOLD: begin
        if (instr_ack_i && r_valid) begin
          w_retire = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
          w_state_nxt = (w_target[1:0] != 2'b00) ? S_ERR : S_FETCH;
`else
          w_state_nxt = S_FETCH;
`endif
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_ERR: w_state_nxt = S_ERR;
`endif
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Datapath registers; the request stays low for the first cycle after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_valid <= 1'b0;
    end else begin
      r_req <= (w_state_nxt == S_FETCH);
      if (w_capture) begin
        r_instr <= imem_rdata_i;
        r_valid <= 1'b1;
      end else if (w_retire) begin
        r_pc    <= w_pc_nxt;
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_err;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_state_nxt == S_ERR);
    end
  end

  assign fetch_err_o = r_err;
`else
  assign fetch_err_o = 1'b0;
`endif

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign pc_plus4_o    = w_pc_plus4;
  assign instr_o       = r_instr;
  assign instr_op_o    = r_instr[31:26];
  assign instr_funct_o = r_instr[5:0];
  assign instr_valid_o = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_ALIGN_CHECK_EN for the trap case.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk, reset_n;
  logic        imem_req_o, imem_ready_i;
  logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, pc_plus4_o, jr_target_i;
  logic [5:0]  instr_op_o, instr_funct_o;
  logic        instr_valid_o, instr_ack_i, jump_ctl_i, branch_ctl_i, branch_taken_i, jr_ctl_i;
  logic        fetch_err_o;
  int          n_checks = 0;
  int          n_fails  = 0;

  fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .instr_o(instr_o), .instr_op_o(instr_op_o), .instr_funct_o(instr_funct_o),
    .instr_valid_o(instr_valid_o), .instr_ack_i(instr_ack_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .jump_ctl_i(jump_ctl_i), .branch_ctl_i(branch_ctl_i), .branch_taken_i(branch_taken_i),
    .jr_ctl_i(jr_ctl_i), .jr_target_i(jr_target_i), .fetch_err_o(fetch_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the request, check its address, answer after lat cycles, check the capture.
  task automatic serve(input logic [31:0] addr, input logic [31:0] rdata, input int lat);
    for (int i = 0; i < 20 && imem_req_o !== 1'b1; i++) @(negedge clk);
    chk_eq("req_seen", {31'd0, imem_req_o}, 32'd1);
    chk_eq("req_addr", imem_addr_o, addr);
    chk_eq("pc_plus4", pc_plus4_o, addr + 32'd4);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk_eq("req_held", {31'd0, imem_req_o}, 32'd1);
      chk_eq("addr_held", imem_addr_o, addr);
    end
    imem_ready_i = 1'b1;
    imem_rdata_i = rdata;
    @(negedge clk);
    imem_ready_i = 1'b0;
    chk_eq("valid_set", {31'd0, instr_valid_o}, 32'd1);
    chk_eq("instr_cap", instr_o, rdata);
    chk_eq("req_drop", {31'd0, imem_req_o}, 32'd0);
  endtask

  // One-cycle ack with the given controls, then check the loaded PC.
  task automatic retire(input logic jr, input logic jmp, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic [31:0] exp_pc);
    jr_ctl_i = jr; jump_ctl_i = jmp; branch_ctl_i = br; branch_taken_i = tk; jr_target_i = tgt;
    instr_ack_i = 1'b1;
    @(negedge clk);
    instr_ack_i = 1'b0; jr_ctl_i = 1'b0; jump_ctl_i = 1'b0; branch_ctl_i = 1'b0; branch_taken_i = 1'b0;
    chk_eq("next_pc", pc_o, exp_pc);
    chk_eq("valid_clr", {31'd0, instr_valid_o}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; imem_ready_i = 1'b0; imem_rdata_i = 32'h0; instr_ack_i = 1'b0;
    jump_ctl_i = 1'b0; branch_ctl_i = 1'b0; branch_taken_i = 1'b0; jr_ctl_i = 1'b0; jr_target_i = 32'h0;
    repeat (2) @(negedge clk);
    chk_eq("rst_pc", pc_o, RST_PC);
    chk_eq("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk_eq("rst_instr", instr_o, 32'h0);
    chk_eq("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk_eq("rst_err", {31'd0, fetch_err_o}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_eq("first_req", {31'd0, imem_req_o}, 32'd1);

    // Sequential fetch with ack held high.
    instr_ack_i = 1'b1;
    serve(32'h0040_0000, 32'h2008_0005, 1);
    chk_eq("op", {26'd0, instr_op_o}, 32'h08);
    chk_eq("funct", {26'd0, instr_funct_o}, 32'h05);
    serve(32'h0040_0004, 32'h2008_0005, 1);
    serve(32'h0040_0008, 32'h0000_0020, 0);
    instr_ack_i = 1'b0;

    // Stall: stray ready while not requesting must be ignored.
    for (int i = 0; i < 5; i++) begin
      imem_ready_i = (i == 2); imem_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk_eq("stall_instr", instr_o, 32'h0000_0020);
      chk_eq("stall_pc", pc_o, 32'h0040_0008);
      chk_eq("stall_req", {31'd0, imem_req_o}, 32'd0);
    end
    imem_ready_i = 1'b0;
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_000C);
    serve(32'h0040_000C, 32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0040_0010);

    // Jump, branch taken back to self, not taken, forward taken.
    serve(32'h0040_0010, 32'h0810_0040, 0);
    retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0100);
    serve(32'h0040_0100, 32'h1000_FFFF, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0040_0100);
    serve(32'h0040_0100, 32'h1000_FFFF, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0040_0104);
    serve(32'h0040_0104, 32'h1000_0003, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0040_0114);

    // JR beats J; wrap at the top of memory; negative branch wraps below zero.
    serve(32'h0040_0114, 32'h0810_0040, 0);
    retire(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_1000);
    serve(32'h0000_1000, 32'h0000_0008, 2);
    retire(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    serve(32'hFFFF_FFFC, 32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);
    serve(32'h0000_0000, 32'h1000_FFFE, 0);
    retire(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);

    // Reset while the request is pending; response at release is discarded.
    #2 reset_n = 1'b0;
    #1;
    chk_eq("arst_req", {31'd0, imem_req_o}, 32'd0);
    chk_eq("arst_pc", pc_o, RST_PC);
    @(negedge clk);
    reset_n = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    imem_ready_i = 1'b0;
    chk_eq("rel_valid", {31'd0, instr_valid_o}, 32'd0);
    chk_eq("rel_instr", instr_o, 32'h0);
    serve(RST_PC, 32'h0000_0000, 0);

    // Misaligned JR target.
    jr_ctl_i = 1'b1; jr_target_i = 32'h0000_1002; instr_ack_i = 1'b1;
    @(negedge clk);
    jr_ctl_i = 1'b0; instr_ack_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk_eq("err_pc", pc_o, 32'h0000_1002);
    for (int i = 0; i < 3; i++) begin
      imem_ready_i = 1'b1; instr_ack_i = 1'b1;
      @(negedge clk);
      chk_eq("err_flag", {31'd0, fetch_err_o}, 32'd1);
      chk_eq("err_req", {31'd0, imem_req_o}, 32'd0);
      chk_eq("err_valid", {31'd0, instr_valid_o}, 32'd0);
    end
    imem_ready_i = 1'b0; instr_ack_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_eq("err_rst", {31'd0, fetch_err_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    serve(RST_PC, 32'h0000_0000, 0);
`else
    chk_eq("mask_pc", pc_o, 32'h0000_1000);
    serve(32'h0000_1000, 32'h0000_0000, 0);
    chk_eq("no_err", {31'd0, fetch_err_o}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
